pmod_share_arbiter: RTL
=======================

# pmod_share_arbiter

Shares the single 3-button / 5-LED PMOD board among up to NUM_CLIENTS independent client blocks. It sits between the PMOD I/O block (debounced button levels in, LED levels out) and the clients. A client gains ownership round-robin by raising its request line. The owner alone receives button clicks and drives the LEDs. Each ownership change is announced by showing the new owner's index on the LEDs for a fixed time.

## Interface
- NUM_CLIENTS, 4: number of requesters, 2..8.
- SHOW_CYCLES, 12_000_000: cycles the owner index is displayed after a grant change, ≥1.
- LONG_PRESS_CYCLES, 24_000_000: btn2 hold time that triggers preemption. Used only with the preempt feature, ≥1.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_CLIENTS  per-client ownership request, level.
- client_leds  in  5*NUM_CLIENTS  LED value per client; client i occupies [5i+4:5i].
- btns  in  3  debounced button levels, 1 = pressed.
- grant  out  NUM_CLIENTS  one-hot owner; all zero when there is no owner.
- grant_valid  out  1  an owner exists.
- grant_idx  out  clog2(NUM_CLIENTS)  owner index; holds its last value when grant_valid is 0.
- clicks  out  3*NUM_CLIENTS  one-cycle click pulses; client i occupies [3i+2:3i].
- leds  out  5  PMOD LED drive.

## Operation
- Click: falling edge of btns[k] (release). Edge detection is internal; btns is registered once.
- FSM states:
  - IDLE: no owner; leds = 0.
  - SHOW: grant held; leds = {1'b1, idx padded to 4 bits}; all clicks suppressed.
  - OWN: leds = owner's client_leds slice; clicks go only to the owner's slice.
- IDLE → SHOW: when any req bit is high, pick the winner (see next item) and load the show counter with SHOW_CYCLES.
- Round-robin pick: search starts at last_owner+1 and wraps at NUM_CLIENTS. last_owner resets to NUM_CLIENTS-1, so the first grant with all requests high goes to client 0.
- SHOW → OWN: when the show counter reaches 0.
- Owner drops req, in SHOW or OWN: release the grant.
  - If any other req is high, pick the next owner in the same cycle and go to SHOW.
  - Otherwise go to IDLE.
- A req from a non-owner never disturbs the current owner (no preemption, except the feature below).
- Simultaneous owner release and new requests are resolved by one pick; there is no idle gap cycle.
- Clicks from several buttons in the same cycle are all delivered.
- A click in IDLE or SHOW is dropped, never queued.
- Async reset mid-operation: all state returns to reset values immediately; pending clicks are lost.

## Timing
- Reset values: grant = 0, grant_valid = 0, grant_idx = 0, clicks = 0, leds = 0; state = IDLE.
- All outputs are registered.
- Grant change: req sampled at edge N → grant, grant_idx and leds updated after edge N.
- Click latency: btns first sampled 0 at edge N, with the previous sample 1 → the click pulse is high for exactly the cycle after edge N+1.
- SHOW lasts exactly SHOW_CYCLES cycles, after which OWN begins.
- Counter width: clog2(max(SHOW_CYCLES, LONG_PRESS_CYCLES) + 1). Counters saturate at 0 and never wrap.

## Configuration
- PMOD_ARB_PREEMPT_EN defined:
  - In OWN, btn2 held continuously for LONG_PRESS_CYCLES while another req is high forces a round-robin pick excluding the owner, then SHOW.
  - The btn2 release that ends that press produces no click.
  - A long press with no other requester behaves as a normal click on release.
- Undefined: no hold counter; btn2 is an ordinary button.

## Structure
- Shared package pmod_pkg holds:
  - the state enum (IDLE, SHOW, OWN);
  - PMOD_LED_W = 5 and PMOD_BTN_N = 3;
  - the LED show-pattern constant (MSB = 1).
- One sub-module, pmod_rr_pick: combinational round-robin picker. Inputs are the req vector, start index and exclude mask. Outputs are the index and a found flag.

## Test plan
Bench parameters: NUM_CLIENTS=4, SHOW_CYCLES=4, LONG_PRESS_CYCLES=8.
- Reset, then req=4'b1111 → grant=0001 and leds=10000 for 4 cycles, then leds = client_leds[4:0].
- In OWN with client 0, press and release btn1 → clicks[1] pulses exactly once; every other clicks bit stays 0.
- Owner 0 drops req while req=4'b1010 → grant=0010 in the following cycle and leds=10001 with no IDLE gap. Then client 1 drops req → grant=1000.
- btn0 released during SHOW → no click on any slice. The same release in IDLE → no click.
- With PMOD_ARB_PREEMPT_EN, owner 1, req=4'b0110, btn2 held 8 cycles → grant=0100; no btn2 click is delivered to either client on release.
- Assert rst mid-SHOW → grant=0 and leds=0 immediately. After release with req=4'b0001 → grant=0001.

Source files
------------

// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared types and constants for the PMOD share arbiter
//
// Purpose: state encoding, PMOD geometry and the owner-announce LED pattern
//          used by pmod_share_arbiter and its helpers.
// Ports:   none (package).

package pmod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      OWN  = 2'd2
   } pmod_state_e;

   localparam int PMOD_LED_W = 5;
   localparam int PMOD_BTN_N = 3;

   // Owner announcement: MSB lit, owner index in the low four LEDs.
   localparam logic [PMOD_LED_W-1:0] PMOD_SHOW_PAT = 5'b10000;

   function automatic logic [PMOD_LED_W-1:0] show_pattern(input logic [3:0] idx);
      return PMOD_SHOW_PAT | {1'b0, idx};
   endfunction

endpackage

// File: rtl/pmod_rr_pick.sv
// rtl/pmod_rr_pick.sv - combinational round-robin picker
//
// Purpose: finds the first requester at or after start (wrapping at N)
//          that is not masked by excl.
// Ports:   req   - request vector
//          start - first index searched
//          excl  - requesters to skip
//          idx   - chosen index (0 when none found)
//          found - a requester was chosen

module pmod_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   input  logic [N-1:0]     excl,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      int c;
      c     = 0;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
         // start + off never exceeds 2N-2, so one subtraction wraps it.
         c = int'(start) + off;
         if (c >= N) c = c - N;
         if (!found && req[c] && !excl[c]) begin
            found = 1'b1;
            idx   = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/pmod_share_arbiter.sv
// rtl/pmod_share_arbiter.sv - round-robin sharing of one 3-button/5-LED PMOD
//
// Purpose: grants the PMOD to one client at a time; the owner gets button
//          release clicks and drives the LEDs. Each new owner index is shown
//          on the LEDs for SHOW_CYCLES before the owner takes over.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          req          - per-client ownership request (level)
//          client_leds  - 5 LED bits per client, client i at [5i+4:5i]
//          btns         - debounced button levels, 1 = pressed
//          grant        - one-hot owner, zero with no owner
//          grant_valid  - an owner exists
//          grant_idx    - owner index, holds last value with no owner
//          clicks       - one-cycle release pulses, client i at [3i+2:3i]
//          leds         - PMOD LED drive
// Option:  PMOD_ARB_PREEMPT_EN - a btn2 long press by the owner hands the
//          board to the next requester.

module pmod_share_arbiter
   import pmod_pkg::*;
#(
   parameter int NUM_CLIENTS       = 4,
   parameter int SHOW_CYCLES       = 12_000_000,
   parameter int LONG_PRESS_CYCLES = 24_000_000,
   localparam int IDX_W            = $clog2(NUM_CLIENTS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            req,
   input  logic [PMOD_LED_W*NUM_CLIENTS-1:0] client_leds,
   input  logic [PMOD_BTN_N-1:0]             btns,
   output logic [NUM_CLIENTS-1:0]            grant,
   output logic                              grant_valid,
   output logic [IDX_W-1:0]                  grant_idx,
   output logic [PMOD_BTN_N*NUM_CLIENTS-1:0] clicks,
   output logic [PMOD_LED_W-1:0]             leds
);

   localparam int CNT_MAX = (SHOW_CYCLES > LONG_PRESS_CYCLES) ? SHOW_CYCLES
                                                               : LONG_PRESS_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES);

   pmod_state_e                       state;
   logic [CNT_W-1:0]                  show_cnt;
   logic [IDX_W-1:0]                  last_owner;
   logic [PMOD_BTN_N-1:0]             btns_q;
   logic [PMOD_BTN_N-1:0]             btns_p;

   logic [IDX_W-1:0]                  start_idx;
   logic [IDX_W-1:0]                  pick_idx;
   logic                              pick_found;
   logic [NUM_CLIENTS-1:0]            pick_onehot;
   logic                              owner_req;
   logic                              other_req;
   logic                              do_pick;
   logic                              preempt;
   logic                              long_hit;
   logic                              suppress;
   logic                              show_last;
   logic [PMOD_BTN_N-1:0]             fall;
   logic [PMOD_BTN_N-1:0]             fall_ok;
   logic [PMOD_BTN_N*NUM_CLIENTS-1:0] clicks_n;
   logic [PMOD_LED_W-1:0]             owner_leds;

   assign start_idx   = (last_owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : last_owner + 1'b1;
   assign pick_onehot = NUM_CLIENTS'(1) << pick_idx;
   // grant is one-hot on the owner (zero in IDLE), so it doubles as the
   // exclude mask: a releasing owner has req low anyway, a preempted owner
   // must be skipped.
   assign owner_req   = |(req & grant);
   assign other_req   = |(req & ~grant);
   assign show_last   = (show_cnt <= CNT_W'(1));
   assign fall        = btns_p & ~btns_q;

   pmod_rr_pick #(
      .N     (NUM_CLIENTS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .start (start_idx),
      .excl  (grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

`ifdef PMOD_ARB_PREEMPT_EN
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LONG_PRESS_CYCLES - 1);

   logic [CNT_W-1:0] hold_cnt;

   // hold_cnt counts down the owner's btn2 hold; zero means the current
   // cycle completes LONG_PRESS_CYCLES of continuous hold. A press that
   // already caused a preemption is ignored until it is released.
   assign long_hit = btns_q[2] && !suppress && (hold_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= HOLD_LOAD;
         suppress <= 1'b0;
      end else begin
         if (state == OWN && btns_q[2] && !suppress) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
         end else begin
            hold_cnt <= HOLD_LOAD;
         end
         if (preempt)      suppress <= 1'b1;
         else if (fall[2]) suppress <= 1'b0;
      end
   end
`else
   assign long_hit = 1'b0;
   assign suppress = 1'b0;
`endif

   always_comb begin
      do_pick = 1'b0;
      preempt = 1'b0;
      case (state)
         IDLE: do_pick = |req;
         SHOW: do_pick = !owner_req;
         OWN: begin
            if (!owner_req) begin
               do_pick = 1'b1;
            end else if (long_hit && other_req) begin
               do_pick = 1'b1;
               preempt = 1'b1;
            end
         end
         default: do_pick = 1'b0;
      endcase
   end

   // The release that ends a preempting long press is not a click.
   always_comb begin
      fall_ok = fall;
      if (suppress) fall_ok[2] = 1'b0;
   end

   always_comb begin
      clicks_n = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (state == OWN && grant[i]) clicks_n[PMOD_BTN_N*i +: PMOD_BTN_N] = fall_ok;
      end
   end

   always_comb begin
      owner_leds = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (grant[i]) owner_leds = client_leds[PMOD_LED_W*i +: PMOD_LED_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         show_cnt    <= '0;
         last_owner  <= IDX_W'(NUM_CLIENTS - 1);
         btns_q      <= '0;
         btns_p      <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         clicks      <= '0;
         leds        <= '0;
      end else begin
         btns_q <= btns;
         btns_p <= btns_q;
         clicks <= clicks_n;
         if (do_pick && pick_found) begin
            state       <= SHOW;
            show_cnt    <= SHOW_LOAD;
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
            last_owner  <= pick_idx;
            leds        <= show_pattern(4'(pick_idx));
         end else if (do_pick) begin
            state       <= IDLE;
            show_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            leds        <= '0;
         end else begin
            case (state)
               SHOW: begin
                  if (show_cnt != '0) show_cnt <= show_cnt - 1'b1;
                  if (show_last) begin
                     state <= OWN;
                     leds  <= owner_leds;
                  end
               end
               OWN:     leds <= owner_leds;
               default: leds <= '0;
            endcase
         end
      end
   end

endmodule
